seg7_scan_mux: RTL and testbench

Multiplexed multi-digit scanner that sits directly upstream of the 7-segment decoder. It holds a frame of digit codes and steps through the digits at a fixed scan rate, presenting one 5-bit code per slot to the decoder. It drives the matching one-hot anode-enable lines with a ghosting guard band and 3-bit PWM brightness. New frames are loaded through a strobe and applied only at frame boundaries, so the display never tears.

---
 rtl/seg7_scan_mux.sv | 141 ++++++++++++++
 tb/tb_seg7_scan_mux.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_mux
// Purpose  : Multi-digit 7-segment scanner with frame-boundary load, anode
//            ghosting guard band and 3-bit PWM brightness. Define SEG7_LZB_EN
//            to add leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_mux #(
    parameter int          NUM_DIGITS   = 4,
    parameter logic [15:0] SCAN_DIV     = 16'd25,
    parameter logic [3:0]  BLANK_CYCLES = 4'd2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [5*NUM_DIGITS-1:0] frame_in,
    input  logic [2:0]              bright,
    output logic [4:0]              digit_code,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_start,
    output logic                    pending
);

    localparam int              c_DW        = $clog2(NUM_DIGITS);
    localparam int              c_FW        = 5 * NUM_DIGITS;
    localparam logic [c_DW-1:0] c_LAST_DIG  = c_DW'(NUM_DIGITS - 1);
    localparam logic [15:0]     c_LAST_SLOT = SCAN_DIV - 16'd1;
    localparam logic [15:0]     c_BLANK     = {12'd0, BLANK_CYCLES};

    logic                  r_run;
    logic [15:0]           r_slot;
    logic [c_DW-1:0]       r_dig;
    logic [2:0]            r_pwm;
    logic [c_FW-1:0]       r_active;
    logic [c_FW-1:0]       r_shadow;

    logic                  w_boundary;
    logic [15:0]           w_slot_nxt;
    logic [c_DW-1:0]       w_dig_nxt;
    logic [2:0]            w_pwm_nxt;
    logic [c_FW-1:0]       w_active_nxt;
    logic [c_FW-1:0]       w_shadow_nxt;
    logic                  w_pending_nxt;
    logic                  w_lit;
    logic [NUM_DIGITS-1:0] w_show;
    logic [NUM_DIGITS-1:0] w_an_nxt;
    logic [4:0]            w_code_nxt;

    // Outputs are registered from the next counter state so that they line up
    // with the counters in the same cycle. r_run holds the counters at zero on
    // the first enabled edge so slot 0 / digit 0 is the first cycle after reset.
    always_comb begin
        w_boundary = r_run && (r_slot == c_LAST_SLOT) && (r_dig == c_LAST_DIG);
        w_slot_nxt = r_slot;
        w_dig_nxt  = r_dig;
        if (!r_run) begin
            w_slot_nxt = '0;
            w_dig_nxt  = '0;
        end else if (r_slot == c_LAST_SLOT) begin
            w_slot_nxt = '0;
            w_dig_nxt  = (r_dig == c_LAST_DIG) ? '0 : r_dig + c_DW'(1);
        end else begin
            w_slot_nxt = r_slot + 16'd1;
        end
        w_pwm_nxt = r_pwm + 3'd1;
    end

    always_comb begin
        w_active_nxt  = r_active;
        w_shadow_nxt  = r_shadow;
        w_pending_nxt = pending;
        if (w_boundary && load) begin
            w_active_nxt  = frame_in;
            w_shadow_nxt  = frame_in;
            w_pending_nxt = 1'b0;
        end else if (w_boundary && pending) begin
            w_active_nxt  = r_shadow;
            w_pending_nxt = 1'b0;
        end else if (load) begin
            w_shadow_nxt  = frame_in;
            w_pending_nxt = 1'b1;
        end
    end

`ifdef SEG7_LZB_EN
    // A digit is shown if it or any more significant digit has a nonzero code.
    logic w_any_hi;
    always_comb begin
        w_show   = '0;
        w_any_hi = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_any_hi  = w_any_hi | (|w_active_nxt[5*i +: 5]);
            w_show[i] = w_any_hi;
        end
        w_show[0] = 1'b1;
    end
`else
    assign w_show = '1;
`endif

    always_comb begin
        w_lit      = (w_slot_nxt >= c_BLANK) && (w_pwm_nxt <= bright);
        w_code_nxt = '0;
        w_an_nxt   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_dig_nxt == c_DW'(i)) begin
                w_code_nxt  = w_active_nxt[5*i +: 5];
                w_an_nxt[i] = w_lit & w_show[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_run       <= 1'b0;
            r_slot      <= '0;
            r_dig       <= '0;
            r_pwm       <= '0;
            r_active    <= '0;
            r_shadow    <= '0;
            digit_code  <= '0;
            an_out      <= '0;
            frame_start <= 1'b0;
            pending     <= 1'b0;
        end else begin
            r_run       <= 1'b1;
            r_slot      <= w_slot_nxt;
            r_dig       <= w_dig_nxt;
            r_pwm       <= w_pwm_nxt;
            r_active    <= w_active_nxt;
            r_shadow    <= w_shadow_nxt;
            digit_code  <= w_code_nxt;
            an_out      <= w_an_nxt;
            frame_start <= (w_slot_nxt == 16'd0) && (w_dig_nxt == '0);
            pending     <= w_pending_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_mux.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_seg7_scan_mux
// Purpose  : Directed self-checking bench for seg7_scan_mux (4 digits,
//            8-cycle slots, 2 guard cycles).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_mux;

    localparam logic [19:0] c_F1 = {5'd4, 5'd3, 5'd2, 5'd1};
    localparam logic [19:0] c_F2 = {5'd8, 5'd7, 5'd6, 5'd5};
`ifdef SEG7_LZB_EN
    localparam logic [3:0]  c_ZMASK = 4'b0001;
    localparam logic [3:0]  c_L1    = 4'b0001;
    localparam logic [3:0]  c_L2    = 4'b0011;
`else
    localparam logic [3:0]  c_ZMASK = 4'b1111;
    localparam logic [3:0]  c_L1    = 4'b1111;
    localparam logic [3:0]  c_L2    = 4'b1111;
`endif

    typedef struct {
        int          cyc;
        logic        ld;
        logic [19:0] frm;
        logic [4:0]  code;
        logic [3:0]  an;
        logic        fs;
        logic        pend;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [19:0] frame_in;
    logic [2:0]  bright;
    logic [4:0]  digit_code;
    logic [3:0]  an_out;
    logic        frame_start;
    logic        pending;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    vec_t vecs[$];

    seg7_scan_mux #(
        .NUM_DIGITS  (4),
        .SCAN_DIV    (16'd8),
        .BLANK_CYCLES(4'd2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .frame_in   (frame_in),
        .bright     (bright),
        .digit_code (digit_code),
        .an_out     (an_out),
        .frame_start(frame_start),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Advance one clock; sample point is 1 ns after the edge. load is a strobe.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        load = 1'b0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        load     = 1'b0;
        frame_in = '0;
        bright   = 3'd7;
        repeat (3) @(posedge clk);
        #1;
        check("rst_code", digit_code, 0);
        check("rst_an", an_out, 0);
        check("rst_fs", frame_start, 0);
        check("rst_pend", pending, 0);
        rst_n = 1'b1;
        cyc   = -1;
        step();
    endtask

    task automatic wait_frame_start(input string name);
        int n = 0;
        while (frame_start !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        n_checks++;
        if (frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: frame_start not seen within 40 cycles (cycle %0d)", name, cyc);
        end
    endtask

    task automatic observe_frame(input string name, input logic [19:0] frm, input logic [3:0] exp_mask);
        logic [3:0] acc = '0;
        load     = 1'b1;
        frame_in = frm;
        step();
        wait_frame_start(name);
        check({name, "_code0"}, digit_code, {27'd0, frm[4:0]});
        for (int i = 0; i < 32; i++) begin
            acc |= an_out;
            check({name, "_onehot"}, ($countones(an_out) <= 1), 1);
            step();
        end
        check({name, "_mask"}, acc, exp_mask);
    endtask

    function automatic vec_t mk(int c, logic ld, logic [19:0] f, logic [4:0] code,
                                logic [3:0] an, logic fs, logic p);
        vec_t v;
        v.cyc  = c;
        v.ld   = ld;
        v.frm  = f;
        v.code = code;
        v.an   = an;
        v.fs   = fs;
        v.pend = p;
        return v;
    endfunction

    initial begin
        logic [3:0] exp_an;
        int         lit;

        // Scan, mid-frame load (cycle 10) and boundary load (cycle 63), bright=7.
        vecs.push_back(mk( 0, 0, '0,   5'd0, 4'b0000, 1, 0));
        vecs.push_back(mk( 1, 0, '0,   5'd0, 4'b0000, 0, 0));
        vecs.push_back(mk( 2, 0, '0,   5'd0, 4'b0001, 0, 0));
        vecs.push_back(mk( 7, 0, '0,   5'd0, 4'b0001, 0, 0));
        vecs.push_back(mk( 8, 0, '0,   5'd0, 4'b0000, 0, 0));
        vecs.push_back(mk(10, 1, c_F1, 5'd0, 4'b0010, 0, 0));
        vecs.push_back(mk(11, 0, '0,   5'd0, 4'b0010, 0, 1));
        vecs.push_back(mk(16, 0, '0,   5'd0, 4'b0000, 0, 1));
        vecs.push_back(mk(18, 0, '0,   5'd0, 4'b0100, 0, 1));
        vecs.push_back(mk(26, 0, '0,   5'd0, 4'b1000, 0, 1));
        vecs.push_back(mk(31, 0, '0,   5'd0, 4'b1000, 0, 1));
        vecs.push_back(mk(32, 0, '0,   5'd1, 4'b0000, 1, 0));
        vecs.push_back(mk(34, 0, '0,   5'd1, 4'b0001, 0, 0));
        vecs.push_back(mk(40, 0, '0,   5'd2, 4'b0000, 0, 0));
        vecs.push_back(mk(42, 0, '0,   5'd2, 4'b0010, 0, 0));
        vecs.push_back(mk(48, 0, '0,   5'd3, 4'b0000, 0, 0));
        vecs.push_back(mk(50, 0, '0,   5'd3, 4'b0100, 0, 0));
        vecs.push_back(mk(56, 0, '0,   5'd4, 4'b0000, 0, 0));
        vecs.push_back(mk(63, 1, c_F2, 5'd4, 4'b1000, 0, 0));
        vecs.push_back(mk(64, 0, '0,   5'd5, 4'b0000, 1, 0));
        vecs.push_back(mk(65, 0, '0,   5'd5, 4'b0000, 0, 0));
        vecs.push_back(mk(66, 0, '0,   5'd5, 4'b0001, 0, 0));
        vecs.push_back(mk(72, 0, '0,   5'd6, 4'b0000, 0, 0));
        vecs.push_back(mk(74, 0, '0,   5'd6, 4'b0010, 0, 0));
        vecs.push_back(mk(96, 0, '0,   5'd5, 4'b0000, 1, 0));

        do_reset();
        foreach (vecs[i]) begin
            while (cyc < vecs[i].cyc) step();
            exp_an = vecs[i].an & ((vecs[i].cyc < 32) ? c_ZMASK : 4'hF);
            check("vec_code", digit_code, vecs[i].code);
            check("vec_an", an_out, exp_an);
            check("vec_fs", frame_start, vecs[i].fs);
            check("vec_pend", pending, vecs[i].pend);
            if (vecs[i].ld) begin
                load     = 1'b1;
                frame_in = vecs[i].frm;
            end
        end

        // Minimum brightness: pwm wraps to 0 in the last cycle of every slot.
        bright = 3'd0;
        step();
        lit = 0;
        for (int i = 0; i < 32; i++) begin
            exp_an = (cyc % 8 == 7) ? (4'b0001 << ((cyc / 8) % 4)) : 4'b0000;
            check("pwm_an", an_out, exp_an);
            if (an_out != 4'b0000) lit++;
            step();
        end
        check("pwm_lit_count", lit, 4);
        bright = 3'd7;

        // Reset while a frame is pending: both frames discarded.
        do_reset();
        while (cyc < 5) step();
        load     = 1'b1;
        frame_in = c_F1;
        while (cyc < 40) step();
        load     = 1'b1;
        frame_in = c_F2;
        repeat (5) begin
            step();
            check("mid_pend", pending, 1);
        end
        check("mid_code", digit_code, 5'd2);
        check("mid_an", an_out, 4'b0010);
        rst_n = 1'b0;
        step();
        check("mrst_an", an_out, 0);
        check("mrst_pend", pending, 0);
        check("mrst_code", digit_code, 0);
        rst_n = 1'b1;
        cyc   = -1;
        step();
        check("mrst_fs0", frame_start, 1);
        for (int i = 0; i < 32; i++) begin
            check("mrst_frame_code", digit_code, 0);
            check("mrst_frame_pend", pending, 0);
            step();
        end
        check("mrst_fs32", frame_start, 1);
        check("mrst_code32", digit_code, 0);

        // Leading-zero blanking (or all digits shown when not built in).
        observe_frame("lzb_d0", 20'h00005, c_L1);
        observe_frame("lzb_d1", 20'h000E0, c_L2);
        observe_frame("lzb_alt", {5'h10, 5'd0, 5'd0, 5'd0}, 4'b1111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
